// File: rtl/uart_periph_pkg.sv
// Shared types and constants for the UART peripheral register-bus arbiter.
// Holds the arbiter FSM encoding, the register offsets and the default read timeout.
package uart_periph_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } arb_state_t;

  localparam logic [31:0] REG_CR  = 32'h0000_0000;
  localparam logic [31:0] REG_ST  = 32'h0000_1000;
  localparam logic [31:0] REG_TNC = 32'h0000_1004;
  localparam logic [31:0] REG_TFC = 32'h0000_1008;
  localparam logic [31:0] REG_TPC = 32'h0000_100C;

  localparam int DEFAULT_TIMEOUT_CYC = 15;

endpackage

// File: rtl/rr_arb_pick.sv
// Round-robin priority picker: one-hot grant to the first asserted request
// found when searching upward from ptr, wrapping at NUM_REQ.
module rr_arb_pick #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant
);

  int   raw_s;
  int   idx_s;
  logic found_s;
  logic hit_s;

  // Walk the requesters in rotated order and keep only the first hit.
  always_comb begin
    grant   = '0;
    found_s = 1'b0;
    raw_s   = 0;
    idx_s   = 0;
    hit_s   = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      raw_s   = int'(ptr) + k;
      idx_s   = (raw_s >= NUM_REQ) ? (raw_s - NUM_REQ) : raw_s;
      hit_s   = !found_s && req[idx_s[IDX_W-1:0]];
      grant[idx_s[IDX_W-1:0]] = grant[idx_s[IDX_W-1:0]] | hit_s;
      found_s = found_s | hit_s;
    end
  end

endmodule

// File: rtl/uart_periph_arbiter.sv
// Arbitrates NUM_REQ command ports onto a single register-block bus with one
// transaction in flight, round-robin fairness and a read-response timeout.
module uart_periph_arbiter
  import uart_periph_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int TIMEOUT_CYC = DEFAULT_TIMEOUT_CYC
) (
  input  logic                  clk_125,
  input  logic                  rst_n_125,
  input  logic [NUM_REQ-1:0]    req_valid,
  input  logic [NUM_REQ-1:0]    req_write,
  input  logic [NUM_REQ*32-1:0] req_addr,
  input  logic [NUM_REQ*32-1:0] req_wdata,
  output logic [NUM_REQ-1:0]    req_ready,
  output logic [NUM_REQ-1:0]    rsp_valid,
  output logic [31:0]           rsp_rdata,
  output logic                  rsp_err,
  output logic [31:0]           periph_addr,
  output logic [31:0]           periph_wdata,
  output logic                  periph_read_en,
  output logic                  periph_write_en,
  input  logic [31:0]           periph_rdata,
  input  logic                  periph_rdata_en
);

  localparam int               IDX_W    = $clog2(NUM_REQ);
  localparam logic [7:0]       CNT_LAST = 8'(TIMEOUT_CYC - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_REQ - 1);

  arb_state_t         state_r, state_nxt_s;
  logic [IDX_W-1:0]   rr_ptr_r, rr_ptr_nxt_s;
  logic [IDX_W-1:0]   winner_r, winner_nxt_s;
  logic [7:0]         cnt_r, cnt_nxt_s;
  logic               write_r, write_nxt_s;
  logic [31:0]        addr_r, addr_nxt_s;
  logic [31:0]        wdata_r, wdata_nxt_s;
  logic               rd_en_r, rd_en_nxt_s;
  logic               wr_en_r, wr_en_nxt_s;
  logic [NUM_REQ-1:0] rsp_valid_r, rsp_valid_nxt_s;
  logic [31:0]        rdata_r, rdata_nxt_s;
  logic               err_r, err_nxt_s;

  logic [NUM_REQ-1:0] grant_s;
  logic [NUM_REQ-1:0] win_onehot_s;
  logic [IDX_W-1:0]   win_idx_s;
  logic [31:0]        sel_addr_s;
  logic [31:0]        sel_wdata_s;
  logic               sel_write_s;

  rr_arb_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_pick (
    .req   (req_valid),
    .ptr   (rr_ptr_r),
    .grant (grant_s)
  );

  assign req_ready    = (state_r == S_IDLE) ? grant_s : '0;
  assign win_onehot_s = {{(NUM_REQ-1){1'b0}}, 1'b1} << winner_r;

  assign rsp_valid       = rsp_valid_r;
  assign rsp_rdata       = rdata_r;
  assign rsp_err         = err_r;
  assign periph_addr     = addr_r;
  assign periph_wdata    = wdata_r;
  assign periph_read_en  = rd_en_r;
  assign periph_write_en = wr_en_r;

  // Mux the winning requester's command fields out of the packed buses.
  always_comb begin
    win_idx_s   = '0;
    sel_addr_s  = 32'h0000_0000;
    sel_wdata_s = 32'h0000_0000;
    sel_write_s = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      win_idx_s   = grant_s[i] ? IDX_W'(i)             : win_idx_s;
      sel_addr_s  = grant_s[i] ? req_addr[32*i +: 32]  : sel_addr_s;
      sel_wdata_s = grant_s[i] ? req_wdata[32*i +: 32] : sel_wdata_s;
      sel_write_s = grant_s[i] ? req_write[i]          : sel_write_s;
    end
  end

  // Next-state and next-output logic for the single-outstanding bus FSM.
  always_comb begin
    state_nxt_s     = state_r;
    rr_ptr_nxt_s    = rr_ptr_r;
    winner_nxt_s    = winner_r;
    cnt_nxt_s       = cnt_r;
    write_nxt_s     = write_r;
    addr_nxt_s      = addr_r;
    wdata_nxt_s     = wdata_r;
    rd_en_nxt_s     = 1'b0;
    wr_en_nxt_s     = 1'b0;
    rsp_valid_nxt_s = '0;
    rdata_nxt_s     = rdata_r;
    err_nxt_s       = err_r;
    case (state_r)
      S_IDLE: begin
        if (|grant_s) begin
          addr_nxt_s   = sel_addr_s;
          wdata_nxt_s  = sel_wdata_s;
          write_nxt_s  = sel_write_s;
          winner_nxt_s = win_idx_s;
          rd_en_nxt_s  = !sel_write_s;
          wr_en_nxt_s  = sel_write_s;
          rr_ptr_nxt_s = (win_idx_s == IDX_LAST) ? '0 : (win_idx_s + IDX_W'(1));
          state_nxt_s  = S_ISSUE;
        end else begin
          state_nxt_s  = S_IDLE;
        end
      end
      S_ISSUE: begin
        cnt_nxt_s = 8'd0;
        if (write_r) begin
          rsp_valid_nxt_s = win_onehot_s;
          rdata_nxt_s     = 32'h0000_0000;
          err_nxt_s       = 1'b0;
          state_nxt_s     = S_RESP;
        end else begin
          state_nxt_s     = S_WAIT;
        end
      end
      S_WAIT: begin
        // Data arriving in the final wait cycle still beats the timeout.
        if (periph_rdata_en) begin
          rsp_valid_nxt_s = win_onehot_s;
          rdata_nxt_s     = periph_rdata;
          err_nxt_s       = 1'b0;
          state_nxt_s     = S_RESP;
        end else if (cnt_r == CNT_LAST) begin
          rsp_valid_nxt_s = win_onehot_s;
          rdata_nxt_s     = 32'h0000_0000;
          err_nxt_s       = 1'b1;
          state_nxt_s     = S_RESP;
        end else begin
          cnt_nxt_s       = cnt_r + 8'd1;
        end
      end
      S_RESP: begin
        state_nxt_s = S_IDLE;
      end
      default: begin
        state_nxt_s = S_IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk_125 or negedge rst_n_125) begin
    if (!rst_n_125) begin
      state_r     <= S_IDLE;
      rr_ptr_r    <= '0;
      winner_r    <= '0;
      cnt_r       <= 8'd0;
      write_r     <= 1'b0;
      addr_r      <= 32'h0000_0000;
      wdata_r     <= 32'h0000_0000;
      rd_en_r     <= 1'b0;
      wr_en_r     <= 1'b0;
      rsp_valid_r <= '0;
      rdata_r     <= 32'h0000_0000;
      err_r       <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      rr_ptr_r    <= rr_ptr_nxt_s;
      winner_r    <= winner_nxt_s;
      cnt_r       <= cnt_nxt_s;
      write_r     <= write_nxt_s;
      addr_r      <= addr_nxt_s;
      wdata_r     <= wdata_nxt_s;
      rd_en_r     <= rd_en_nxt_s;
      wr_en_r     <= wr_en_nxt_s;
      rsp_valid_r <= rsp_valid_nxt_s;
      rdata_r     <= rdata_nxt_s;
      err_r       <= err_nxt_s;
    end
  end

endmodule

// File: tb/tb_uart_periph_arbiter.sv
// Directed self-checking bench for uart_periph_arbiter with a small register-block responder.
module tb_uart_periph_arbiter;

  logic         clk_125;
  logic         rst_n_125;
  logic [3:0]   req_valid;
  logic [3:0]   req_write;
  logic [127:0] req_addr;
  logic [127:0] req_wdata;
  logic [3:0]   req_ready;
  logic [3:0]   rsp_valid;
  logic [31:0]  rsp_rdata;
  logic         rsp_err;
  logic [31:0]  periph_addr;
  logic [31:0]  periph_wdata;
  logic         periph_read_en;
  logic         periph_write_en;
  logic [31:0]  periph_rdata;
  logic         periph_rdata_en;

  logic         slave_rd_en;
  logic         stray_en;
  logic [31:0]  rdata_drv;
  int           checks;
  int           errors;
  int           n;
  logic         seen;

  uart_periph_arbiter dut (
    .clk_125         (clk_125),
    .rst_n_125       (rst_n_125),
    .req_valid       (req_valid),
    .req_write       (req_write),
    .req_addr        (req_addr),
    .req_wdata       (req_wdata),
    .req_ready       (req_ready),
    .rsp_valid       (rsp_valid),
    .rsp_rdata       (rsp_rdata),
    .rsp_err         (rsp_err),
    .periph_addr     (periph_addr),
    .periph_wdata    (periph_wdata),
    .periph_read_en  (periph_read_en),
    .periph_write_en (periph_write_en),
    .periph_rdata    (periph_rdata),
    .periph_rdata_en (periph_rdata_en)
  );

  initial clk_125 = 1'b0;
  always #4 clk_125 = ~clk_125;

  function automatic logic is_mapped(input logic [31:0] a);
    return (a == 32'h0000_0000) || (a == 32'h0000_1000) || (a == 32'h0000_1004) ||
           (a == 32'h0000_1008) || (a == 32'h0000_100C);
  endfunction

  // Register block answers a mapped read one cycle after the strobe.
  always @(posedge clk_125) slave_rd_en <= periph_read_en && is_mapped(periph_addr);

  assign periph_rdata_en = slave_rd_en | stray_en;
  assign periph_rdata    = rdata_drv;

  task automatic tick();
    @(posedge clk_125);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    checks      = 0;
    errors      = 0;
    slave_rd_en = 1'b0;
    stray_en    = 1'b0;
    rdata_drv   = 32'h0;
    rst_n_125   = 1'b0;
    req_valid   = 4'b0000;
    req_write   = 4'b0000;
    req_addr    = 128'h0;
    req_wdata   = 128'h0;
    tick();
    tick();

    // Reset state
    chk("rst_read_en",   32'(periph_read_en),  32'h0);
    chk("rst_write_en",  32'(periph_write_en), 32'h0);
    chk("rst_rsp_valid", 32'(rsp_valid),       32'h0);
    chk("rst_ready_idle", 32'(req_ready),      32'h0);
    req_valid = 4'b0100;
    #1 chk("rst_ready_pick2", 32'(req_ready), 32'h4);

    // Round-robin order from reset, all four reading mapped registers
    req_addr  = {32'h0000_100C, 32'h0000_1008, 32'h0000_1004, 32'h0000_1000};
    rdata_drv = 32'h0000_00AA;
    req_valid = 4'b1111;
    #1 chk("rst_ready_pick0", 32'(req_ready), 32'h1);
    rst_n_125 = 1'b1;
    for (int g = 0; g < 5; g++) begin
      chk("rr_order_ready", 32'(req_ready), 32'(4'b0001 << (g % 4)));
      tick();
      tick();
      tick();
      chk("rr_order_rsp", 32'(rsp_valid), 32'(4'b0001 << (g % 4)));
      tick();
    end
    req_valid = 4'b0000;
    tick();

    // Mapped read latency and data
    req_addr[31:0] = 32'h0000_1000;
    rdata_drv      = 32'h0003_0201;
    req_valid      = 4'b0001;
    #1 chk("rd_ready", 32'(req_ready), 32'h1);
    tick();
    chk("rd_read_en", 32'(periph_read_en), 32'h1);
    chk("rd_addr", periph_addr, 32'h0000_1000);
    chk("rd_ready_busy", 32'(req_ready), 32'h0);
    req_valid = 4'b0000;
    tick();
    chk("rd_read_en_pulse", 32'(periph_read_en), 32'h0);
    chk("rd_rsp_early", 32'(rsp_valid), 32'h0);
    tick();
    chk("rd_rsp_valid", 32'(rsp_valid), 32'h1);
    chk("rd_rdata", rsp_rdata, 32'h0003_0201);
    chk("rd_err", 32'(rsp_err), 32'h0);
    tick();
    chk("rd_rsp_pulse", 32'(rsp_valid), 32'h0);
    chk("rd_rdata_hold", rsp_rdata, 32'h0003_0201);

    // Unmapped read times out after TIMEOUT_CYC wait cycles
    req_addr[63:32] = 32'h0000_2000;
    req_valid       = 4'b0010;
    #1 chk("to_ready", 32'(req_ready), 32'h2);
    tick();
    chk("to_read_en", 32'(periph_read_en), 32'h1);
    req_valid = 4'b0000;
    n = 0;
    while (rsp_valid == 4'b0000 && n < 40) begin
      tick();
      n++;
    end
    chk("to_latency", 32'(n), 32'd16);
    chk("to_rsp_valid", 32'(rsp_valid), 32'h2);
    chk("to_rdata", rsp_rdata, 32'h0);
    chk("to_err", 32'(rsp_err), 32'h1);
    tick();
    chk("to_rsp_pulse", 32'(rsp_valid), 32'h0);
    chk("to_err_hold", 32'(rsp_err), 32'h1);

    // Write
    req_addr[95:64]  = 32'h0000_0000;
    req_wdata[95:64] = 32'h1234_5678;
    req_write        = 4'b0100;
    req_valid        = 4'b0100;
    #1 chk("wr_ready", 32'(req_ready), 32'h4);
    tick();
    chk("wr_write_en", 32'(periph_write_en), 32'h1);
    chk("wr_read_en", 32'(periph_read_en), 32'h0);
    chk("wr_addr", periph_addr, 32'h0);
    chk("wr_wdata", periph_wdata, 32'h1234_5678);
    req_valid = 4'b0000;
    req_write = 4'b0000;
    tick();
    chk("wr_write_en_pulse", 32'(periph_write_en), 32'h0);
    chk("wr_rsp_valid", 32'(rsp_valid), 32'h4);
    chk("wr_err", 32'(rsp_err), 32'h0);
    chk("wr_rdata", rsp_rdata, 32'h0);
    tick();
    chk("wr_rsp_pulse", 32'(rsp_valid), 32'h0);
    chk("wr_addr_hold", periph_addr, 32'h0);
    chk("wr_wdata_hold", periph_wdata, 32'h1234_5678);

    // Read data in the final wait cycle beats the timeout
    req_addr[127:96] = 32'h0000_3000;
    req_valid        = 4'b1000;
    #1 chk("late_ready", 32'(req_ready), 32'h8);
    tick();
    req_valid = 4'b0000;
    repeat (15) tick();
    chk("late_no_rsp_yet", 32'(rsp_valid), 32'h0);
    stray_en  = 1'b1;
    rdata_drv = 32'hCAFE_F00D;
    tick();
    stray_en = 1'b0;
    chk("late_rsp_valid", 32'(rsp_valid), 32'h8);
    chk("late_err", 32'(rsp_err), 32'h0);
    chk("late_rdata", rsp_rdata, 32'hCAFE_F00D);
    tick();

    // Stray read-data qualifier in IDLE is ignored
    rdata_drv = 32'h0000_0055;
    stray_en  = 1'b1;
    tick();
    stray_en = 1'b0;
    chk("stray_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("stray_rdata_hold", rsp_rdata, 32'hCAFE_F00D);
    tick();
    chk("stray_still_quiet", 32'(rsp_valid), 32'h0);

    // Reset in the middle of a waiting read
    req_valid = 4'b0010;
    #1 chk("mid_ready", 32'(req_ready), 32'h2);
    tick();
    req_valid = 4'b0000;
    tick();
    tick();
    tick();
    rst_n_125 = 1'b0;
    #1;
    chk("mid_rst_read_en",  32'(periph_read_en),  32'h0);
    chk("mid_rst_write_en", 32'(periph_write_en), 32'h0);
    chk("mid_rst_addr",     periph_addr,          32'h0);
    chk("mid_rst_wdata",    periph_wdata,         32'h0);
    chk("mid_rst_rsp",      32'(rsp_valid),       32'h0);
    chk("mid_rst_rdata",    rsp_rdata,            32'h0);
    chk("mid_rst_err",      32'(rsp_err),         32'h0);
    req_valid = 4'b1010;
    #1 chk("mid_rst_ready", 32'(req_ready), 32'h2);
    req_valid = 4'b0000;
    tick();
    rst_n_125 = 1'b1;
    seen = 1'b0;
    repeat (20) begin
      tick();
      if (rsp_valid != 4'b0000) seen = 1'b1;
    end
    chk("mid_rst_dropped", 32'(seen), 32'h0);
    req_valid = 4'b1001;
    #1 chk("post_rst_ready", 32'(req_ready), 32'h1);
    tick();
    chk("post_rst_read_en", 32'(periph_read_en), 32'h1);
    chk("post_rst_addr", periph_addr, 32'h0000_1000);
    req_valid = 4'b0000;
    repeat (4) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_periph_arbiter.md
UART_PERIPH_ARBITER -- requirements
Module: uart_periph_arbiter

Interface
REQ-001 The block SHALL have parameter NUM_REQ, default 4, giving the number of requesters (range 2..8).
REQ-002 The block SHALL have parameter TIMEOUT_CYC, default 15, giving the read-response wait limit in cycles (range 2..255).
REQ-003 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-004 Port clk_125, in, 1: the only clock.
REQ-005 Port rst_n_125, in, 1: asynchronous active-low reset.
REQ-006 Port req_valid, in, NUM_REQ: per-requester command pending; held until accepted.
REQ-007 Port req_write, in, NUM_REQ: per-requester 1=write, 0=read.
REQ-008 Port req_addr, in, NUM_REQ*32: per-requester byte address, requester i at bits [32i+31:32i].
REQ-009 Port req_wdata, in, NUM_REQ*32: per-requester write data, packed the same way as req_addr.
REQ-010 Port req_ready, out, NUM_REQ: one-hot accept strobe.
REQ-011 Port rsp_valid, out, NUM_REQ: one-hot, one-cycle completion strobe.
REQ-012 Port rsp_rdata, out, 32: read data, valid with rsp_valid.
REQ-013 Port rsp_err, out, 1: read timeout, valid with rsp_valid.
REQ-014 Port periph_addr, out, 32: drives the register block address.
REQ-015 Port periph_wdata, out, 32: drives the register block write data.
REQ-016 Port periph_read_en, out, 1: one-cycle read strobe.
REQ-017 Port periph_write_en, out, 1: one-cycle write strobe.
REQ-018 Port periph_rdata, in, 32: register block read data.
REQ-019 Port periph_rdata_en, in, 1: register block read-data qualifier; asserts 1 cycle after periph_read_en for mapped addresses and never for unmapped ones.

Function
REQ-020 The FSM SHALL have states IDLE, ISSUE, WAIT, RESP, with exactly one bus transaction outstanding at a time.
REQ-021 In IDLE the arbiter SHALL grant the first asserted req_valid searching round-robin from rr_ptr.
- req_ready[winner] is combinational and high in IDLE only.
- On the accept edge: latch addr, wdata, write and the winner index; set rr_ptr = (winner+1) mod NUM_REQ; go to ISSUE.
REQ-022 In ISSUE the block SHALL drive periph_read_en or periph_write_en high for exactly one cycle, with periph_addr and periph_wdata from the latch.
- Write: go to RESP.
- Read: clear the timeout counter; go to WAIT.
REQ-023 In WAIT the block SHALL go to RESP on periph_rdata_en=1, capturing periph_rdata and setting err=0.
- Otherwise it increments the counter.
- When counter = TIMEOUT_CYC-1 without periph_rdata_en: go to RESP with rdata=0, err=1.
REQ-024 In RESP the block SHALL pulse rsp_valid[winner] for one cycle with rsp_rdata/rsp_err registered (writes: rdata=0, err=0), then return to IDLE.
REQ-025 Mapped-read latency: accept at edge T, read_en during T+1, rdata_en during T+2, rsp_valid during T+3; a write gives rsp_valid during T+2.
REQ-026 periph_rdata_en outside WAIT SHALL be ignored.
REQ-027 periph_rdata_en in the timeout cycle SHALL win over the timeout (err=0).
REQ-028 A requester that drops req_valid before accept SHALL lose arbitration without a response.
REQ-029 periph_addr and periph_wdata SHALL hold their last values between strobes.
REQ-030 rsp_rdata and rsp_err SHALL hold their last values between strobes.

Reset
REQ-031 While rst_n_125=0 the block SHALL be in IDLE, with rr_ptr=0 and the counter=0.
REQ-032 While rst_n_125=0 every output SHALL be 0, except req_ready, which follows the REQ-021 combinational logic from IDLE; an in-flight transaction is dropped with no rsp_valid.

Structure
REQ-033 Package uart_periph_pkg SHALL hold the FSM state enum, the register offset constants (CR 0x0000, ST 0x1000, TNC 0x1004, TFC 0x1008, TPC 0x100C) and the default TIMEOUT_CYC.
REQ-034 The round-robin priority picker SHALL be a sub-module, rr_arb_pick (inputs: req vector and pointer; output: one-hot grant), and the FSM SHALL be inline.

Verification
REQ-035 Read to mapped 0x1000, with the slave returning 0x00030201 one cycle later -> rsp_valid[0] at T+3, rsp_rdata=0x00030201, rsp_err=0.
REQ-036 Requesters 0..3 all valid with reads from reset -> grant order 0,1,2,3,0, with no requester starved.
REQ-037 Read to unmapped 0x2000, no rdata_en -> rsp_valid after TIMEOUT_CYC WAIT cycles, rdata=0, err=1.
REQ-038 Write 0x12345678 to 0x0000 -> one-cycle write_en with that address and data; rsp_valid at T+2, err=0.
REQ-039 Stray periph_rdata_en in IDLE, then reset asserted mid-WAIT -> stray ignored; after reset all outputs 0, IDLE, next grant to requester 0.
